// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lib_uart_arb (package)
// Description : Shared types and helpers for the two-port UART TX arbiter.
//               Holds the arbiter state encoding, the port identifiers and the
//               round-robin selection helper used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package lib_uart_arb;

    // Arbiter sequencing: IDLE picks a port, ISSUE drives the one-cycle
    // request, WAIT_BUSY waits for the transmitter to accept, WAIT_DONE
    // waits for it to finish shifting the byte out.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } ARB_STATE;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Round-robin pick between the two ports. With both pending, the port
    // that did not win last time is chosen; otherwise the pending one.
    // Only meaningful when at least one port is pending.
    function automatic logic pick_port(
        input logic pend_cpu,
        input logic pend_dbg,
        input logic last_grant
    );
        logic sel;
        if (pend_cpu && pend_dbg) begin
            sel = ~last_grant;
        end else if (pend_cpu) begin
            sel = PORT_CPU;
        end else begin
            sel = PORT_DBG;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_capture.sv
`default_nettype none
// ============================================================================
// Module      : tx_req_capture
// Description : Per-port request front end for the UART TX arbiter.
//               Detects the rising edge of the requester's level signal,
//               holds one byte until the arbiter takes it, and raises a
//               sticky overrun flag when a byte arrives that cannot be held.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   req      in   requester level; a 0->1 transition offers one byte
//   data     in   byte offered with the edge
//   take     in   arbiter grant: the held byte has been copied out
//   owned    in   this port currently owns the transmitter
//   pending  out  a byte is held and waiting for a grant
//   data_q   out  the held byte
//   ovf      out  sticky overrun flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module tx_req_capture
    import lib_uart_arb::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    input  logic              take,
    input  logic              owned,
    output logic              pending,
    output logic [DATA_W-1:0] data_q,
    output logic              ovf
);

    logic              r_req_q;
    logic              r_pending;
    logic              r_ovf;
    logic [DATA_W-1:0] r_data;
    logic              w_edge;

    assign w_edge = req & ~r_req_q;

    // A take always coincides with r_pending=1, so an edge in that same
    // cycle is treated as an overrun and never collides with the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_q   <= 1'b0;
            r_pending <= 1'b0;
            r_ovf     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_req_q <= req;
            if (take) begin
                r_pending <= 1'b0;
            end
            if (w_edge) begin
                if (r_pending || owned) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                    r_data    <= data;
                end
            end
        end
    end

    assign pending = r_pending;
    assign data_q  = r_data;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter between the CPU (port 0) and the
//               debug streamer (port 1). Each port sees a transmitter-like
//               req/data/busy interface. Bytes are captured per port, granted
//               round-robin, issued to the UART as a one-cycle request, and
//               the UART busy signal is tracked until the byte is out.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   cpu_tx_req   in   port 0 request level (rising edge = one byte)
//   cpu_tx_data  in   port 0 byte
//   cpu_tx_busy  out  port 0 byte pending or in flight
//   cpu_tx_ovf   out  port 0 sticky overrun
//   dbg_tx_*     --   same set for port 1
//   tx_req       out  one-cycle request to the UART transmitter
//   tx_data      out  byte to the UART, stable from issue to next grant
//   tx_busy      in   UART transmitter busy
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import lib_uart_arb::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_tx_req,
    input  logic [DATA_W-1:0] cpu_tx_data,
    output logic              cpu_tx_busy,
    output logic              cpu_tx_ovf,
    input  logic              dbg_tx_req,
    input  logic [DATA_W-1:0] dbg_tx_data,
    output logic              dbg_tx_busy,
    output logic              dbg_tx_ovf,
    output logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy
);

    ARB_STATE          r_state;
    ARB_STATE          w_state_nxt;
    logic              r_owner;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_tx_data;

    logic              w_grant;
    logic              w_grant_port;
    logic              w_in_use;
    logic [1:0]        w_pend;
    logic [1:0]        w_take;
    logic [1:0]        w_owned;
    logic [DATA_W-1:0] w_cpu_byte;
    logic [DATA_W-1:0] w_dbg_byte;

    // ------------------------------------------------------------------
    // Per-port capture
    // ------------------------------------------------------------------
    tx_req_capture #(
        .DATA_W (DATA_W)
    ) u_cap_cpu (
        .clk     (clk),
        .reset   (reset),
        .req     (cpu_tx_req),
        .data    (cpu_tx_data),
        .take    (w_take[0]),
        .owned   (w_owned[0]),
        .pending (w_pend[0]),
        .data_q  (w_cpu_byte),
        .ovf     (cpu_tx_ovf)
    );

    tx_req_capture #(
        .DATA_W (DATA_W)
    ) u_cap_dbg (
        .clk     (clk),
        .reset   (reset),
        .req     (dbg_tx_req),
        .data    (dbg_tx_data),
        .take    (w_take[1]),
        .owned   (w_owned[1]),
        .pending (w_pend[1]),
        .data_q  (w_dbg_byte),
        .ovf     (dbg_tx_ovf)
    );

    // ------------------------------------------------------------------
    // Ownership and grant selection
    // ------------------------------------------------------------------
    assign w_in_use     = (r_state != IDLE);
    assign w_owned[0]   = w_in_use && (r_owner == PORT_CPU);
    assign w_owned[1]   = w_in_use && (r_owner == PORT_DBG);
    assign w_grant_port = pick_port(w_pend[0], w_pend[1], r_last_grant);
    assign w_take[0]    = w_grant && (w_grant_port == PORT_CPU);
    assign w_take[1]    = w_grant && (w_grant_port == PORT_DBG);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                // A busy transmitter here belongs to someone else (or to a
                // transfer cut short by reset); never stack a request on it.
                if (!tx_busy && (|w_pend)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state and grant registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= PORT_CPU;
            r_last_grant <= PORT_DBG;
            r_tx_data    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner      <= w_grant_port;
                r_last_grant <= w_grant_port;
                r_tx_data    <= (w_grant_port == PORT_DBG) ? w_dbg_byte : w_cpu_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived directly from registers
    // ------------------------------------------------------------------
    assign tx_req      = (r_state == ISSUE);
    assign tx_data     = r_tx_data;
    assign cpu_tx_busy = w_pend[0] | w_owned[0];
    assign dbg_tx_busy = w_pend[1] | w_owned[1];

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. A behavioural model
//               of the arbiter rules and a simple UART busy model run beside
//               the DUT; directed scenarios are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_tx_req = 1'b0;
    logic [DATA_W-1:0] cpu_tx_data = '0;
    logic              cpu_tx_busy;
    logic              cpu_tx_ovf;
    logic              dbg_tx_req = 1'b0;
    logic [DATA_W-1:0] dbg_tx_data = '0;
    logic              dbg_tx_busy;
    logic              dbg_tx_ovf;
    logic              tx_req;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_tx_req  (cpu_tx_req),
        .cpu_tx_data (cpu_tx_data),
        .cpu_tx_busy (cpu_tx_busy),
        .cpu_tx_ovf  (cpu_tx_ovf),
        .dbg_tx_req  (dbg_tx_req),
        .dbg_tx_data (dbg_tx_data),
        .dbg_tx_busy (dbg_tx_busy),
        .dbg_tx_ovf  (dbg_tx_ovf),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // UART transmitter model: after a request, waits cfg_delay cycles and
    // then reports busy for cfg_len cycles. ext_busy models foreign use.
    // ------------------------------------------------------------------
    int cfg_delay = 1;
    int cfg_len   = 4;
    int u_wait    = 0;
    int u_left    = 0;
    bit u_busy    = 1'b0;
    bit ext_busy  = 1'b0;
    assign tx_busy = u_busy | ext_busy;

    // ------------------------------------------------------------------
    // Reference model of the arbiter rules.
    // holder: port using the transmitter, -1 when the arbiter is free.
    // pulse : the request to the UART is expected in the current cycle.
    // seen  : the transmitter has been observed busy for this transfer.
    // ------------------------------------------------------------------
    bit         m_pend[2];
    logic [7:0] m_byte[2];
    bit         m_ovf[2];
    bit         m_prev[2];
    int         m_holder;
    int         m_last;
    bit         m_pulse;
    bit         m_seen;
    logic [7:0] m_txdata;

    logic [7:0] issued[$];

    task automatic model_tick(input bit rst, input bit r0, input bit r1,
                              input logic [7:0] d0, input logic [7:0] d1, input bit tb);
        bit         r[2];
        logic [7:0] d[2];
        bit         old_pend[2];
        int         old_holder;
        int         g;
        r[0] = r0; r[1] = r1; d[0] = d0; d[1] = d1;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                m_pend[p] = 0; m_ovf[p] = 0; m_prev[p] = 0; m_byte[p] = '0;
            end
            m_holder = -1; m_last = 1; m_pulse = 0; m_seen = 0; m_txdata = '0;
            return;
        end
        old_pend   = m_pend;
        old_holder = m_holder;
        if (m_holder < 0) begin
            if (!tb && (m_pend[0] || m_pend[1])) begin
                if (m_pend[0] && m_pend[1]) g = (m_last == 1) ? 0 : 1;
                else                        g = m_pend[0] ? 0 : 1;
                m_holder  = g;
                m_last    = g;
                m_txdata  = m_byte[g];
                m_pend[g] = 0;
                m_pulse   = 1;
                m_seen    = 0;
            end
        end else if (m_pulse) begin
            m_pulse = 0;
        end else if (!m_seen) begin
            m_seen = tb;
        end else if (!tb) begin
            m_holder = -1;
        end
        for (int p = 0; p < 2; p++) begin
            if (r[p] && !m_prev[p]) begin
                if (old_pend[p] || old_holder == p) m_ovf[p] = 1;
                else begin
                    m_pend[p] = 1;
                    m_byte[p] = d[p];
                end
            end
            m_prev[p] = r[p];
        end
    endtask

    // One clock: model update at the active edge, compare on the falling
    // edge, then advance the transmitter model.
    task automatic step();
        @(posedge clk);
        cyc++;
        model_tick(reset, cpu_tx_req, dbg_tx_req, cpu_tx_data, dbg_tx_data, tx_busy);
        @(negedge clk);
        chk_eq("tx_req",   32'(tx_req),      32'(m_pulse));
        chk_eq("tx_data",  32'(tx_data),     32'(m_txdata));
        chk_eq("cpu_busy", 32'(cpu_tx_busy), 32'(m_pend[0] || m_holder == 0));
        chk_eq("dbg_busy", 32'(dbg_tx_busy), 32'(m_pend[1] || m_holder == 1));
        chk_eq("cpu_ovf",  32'(cpu_tx_ovf),  32'(m_ovf[0]));
        chk_eq("dbg_ovf",  32'(dbg_tx_ovf),  32'(m_ovf[1]));
        if (tx_req) issued.push_back(tx_data);
        if (tx_req) begin
            u_wait = cfg_delay;
            u_left = cfg_len;
        end else if (u_wait > 0) begin
            u_wait--;
        end else if (u_left > 0) begin
            u_left--;
        end
        u_busy = (u_wait == 0) && (u_left > 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        cpu_tx_req = 0;
        dbg_tx_req = 0;
        reset      = 1;
        steps(n);
        reset = 0;
        issued.delete();
    endtask

    task automatic wait_pulse(input string tag, input int max);
        int n;
        n = 0;
        while (tx_req !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk_eq(tag, 32'(tx_req), 32'd1);
    endtask

    task automatic wait_tx_busy(input string tag, input bit level, input int max);
        int n;
        n = 0;
        while (tx_busy !== level && n < max) begin
            step();
            n++;
        end
        chk_eq(tag, 32'(tx_busy), 32'(level));
    endtask

    initial begin
        int t0;
        int fed0;
        int fed1;

        // Reset state
        @(negedge clk);
        do_reset(2);
        chk_eq("rst_outputs", 32'({cpu_tx_busy, dbg_tx_busy, cpu_tx_ovf, dbg_tx_ovf, tx_req}), 32'd0);
        chk_eq("rst_tx_data", 32'(tx_data), 32'd0);

        // 1: single CPU byte, 20-cycle transmitter
        cfg_delay = 1; cfg_len = 20;
        steps(6);
        cpu_tx_data = 8'h41; cpu_tx_req = 1; t0 = cyc;
        wait_pulse("s1_pulse", 10);
        chk_eq("s1_latency", 32'(cyc - t0), 32'd2);
        chk_eq("s1_data", 32'(tx_data), 32'h41);
        steps(30);
        cpu_tx_req = 0;
        steps(2);
        chk_eq("s1_count", 32'(issued.size()), 32'd1);
        chk_eq("s1_busy_done", 32'(cpu_tx_busy), 32'd0);

        // 2: simultaneous requests after reset, port 0 wins the tie
        do_reset(1);
        cfg_delay = 1; cfg_len = 5;
        cpu_tx_data = 8'h55; dbg_tx_data = 8'hAA;
        cpu_tx_req = 1; dbg_tx_req = 1;
        step();
        chk_eq("s2_both_busy", 32'({cpu_tx_busy, dbg_tx_busy}), 32'b11);
        cpu_tx_req = 0; dbg_tx_req = 0;
        steps(40);
        chk_eq("s2_count", 32'(issued.size()), 32'd2);
        chk_eq("s2_first", 32'(issued[0]), 32'h55);
        chk_eq("s2_second", 32'(issued[1]), 32'hAA);

        // 3: alternating contention, six bytes
        do_reset(1);
        cfg_delay = 2; cfg_len = 3;
        fed0 = 0; fed1 = 0;
        for (int n = 0; n < 400 && issued.size() < 6; n++) begin
            if (cpu_tx_req) cpu_tx_req = 0;
            else if (fed0 < 3 && !m_pend[0] && m_holder != 0) begin
                cpu_tx_data = 8'(8'hC0 + fed0); cpu_tx_req = 1; fed0++;
            end
            if (dbg_tx_req) dbg_tx_req = 0;
            else if (fed1 < 3 && !m_pend[1] && m_holder != 1) begin
                dbg_tx_data = 8'(8'hD0 + fed1); dbg_tx_req = 1; fed1++;
            end
            step();
        end
        cpu_tx_req = 0; dbg_tx_req = 0;
        steps(20);
        chk_eq("s3_count", 32'(issued.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] exp_b;
            exp_b = (i % 2 == 0) ? 8'(8'hC0 + i / 2) : 8'(8'hD0 + i / 2);
            chk_eq("s3_order", 32'(issued[i]), 32'(exp_b));
        end

        // 4: CPU re-toggles while its byte is in flight
        do_reset(1);
        cfg_delay = 1; cfg_len = 10;
        cpu_tx_data = 8'h31; cpu_tx_req = 1;
        step();
        cpu_tx_req = 0;
        wait_tx_busy("s4_uart_busy", 1'b1, 10);
        steps(2);
        cpu_tx_data = 8'h32; cpu_tx_req = 1;
        dbg_tx_data = 8'h99; dbg_tx_req = 1;
        step();
        cpu_tx_req = 0; dbg_tx_req = 0;
        chk_eq("s4_ovf_set", 32'(cpu_tx_ovf), 32'd1);
        steps(40);
        chk_eq("s4_count", 32'(issued.size()), 32'd2);
        chk_eq("s4_first", 32'(issued[0]), 32'h31);
        chk_eq("s4_second", 32'(issued[1]), 32'h99);
        chk_eq("s4_ovf_sticky", 32'(cpu_tx_ovf), 32'd1);
        chk_eq("s4_dbg_ovf", 32'(dbg_tx_ovf), 32'd0);

        // 5: reset in WAIT_BUSY with port 1 pending
        do_reset(1);
        cfg_delay = 4; cfg_len = 10;
        cpu_tx_data = 8'h21; cpu_tx_req = 1;
        wait_pulse("s5_pulse", 10);
        cpu_tx_req = 0;
        dbg_tx_data = 8'h22; dbg_tx_req = 1;
        step();
        chk_eq("s5_dbg_pending", 32'(dbg_tx_busy), 32'd1);
        dbg_tx_req = 0; reset = 1;
        step();
        reset = 0;
        chk_eq("s5_rst_outputs", 32'({cpu_tx_busy, dbg_tx_busy, cpu_tx_ovf, dbg_tx_ovf, tx_req}), 32'd0);
        chk_eq("s5_rst_tx_data", 32'(tx_data), 32'd0);
        wait_tx_busy("s5_uart_rise", 1'b1, 10);
        wait_tx_busy("s5_uart_fall", 1'b0, 20);
        chk_eq("s5_no_issue", 32'(issued.size()), 32'd1);
        dbg_tx_data = 8'h23; dbg_tx_req = 1;
        wait_pulse("s5_fresh_pulse", 10);
        dbg_tx_req = 0;
        chk_eq("s5_fresh_data", 32'(tx_data), 32'h23);
        steps(20);

        // 6: transmitter held busy externally
        do_reset(1);
        cfg_delay = 1; cfg_len = 3;
        ext_busy = 1;
        dbg_tx_data = 8'h7E; dbg_tx_req = 1;
        step();
        dbg_tx_req = 0;
        steps(8);
        chk_eq("s6_held", 32'(issued.size()), 32'd0);
        chk_eq("s6_dbg_busy", 32'(dbg_tx_busy), 32'd1);
        ext_busy = 0;
        wait_pulse("s6_pulse", 10);
        chk_eq("s6_data", 32'(tx_data), 32'h7E);
        steps(15);

        // 7: random traffic against the model
        do_reset(1);
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cpu_tx_req  = ~cpu_tx_req;
                cpu_tx_data = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                dbg_tx_req  = ~dbg_tx_req;
                dbg_tx_data = 8'($urandom);
            end
            if (ext_busy) begin
                if ($urandom_range(0, 4) == 0) ext_busy = 0;
            end else if ($urandom_range(0, 59) == 0) begin
                ext_busy = 1;
            end
            cfg_delay = $urandom_range(0, 3);
            cfg_len   = $urandom_range(1, 6);
            if ($urandom_range(0, 399) == 0) begin
                cpu_tx_req = 0; dbg_tx_req = 0; reset = 1;
            end else begin
                reset = 0;
            end
            step();
        end
        reset = 0; ext_busy = 0;
        cpu_tx_req = 0; dbg_tx_req = 0;
        steps(30);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
